alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_shift_step.sv | 42 ++++
 rtl/alu_exec_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_Cnt operation codes, execute-unit FSM encoding and flag bit positions.
// Also used by the ALU control unit when it decodes instructions.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_RSV5 = 4'b0101;
    localparam logic [3:0] ALU_MOV  = 4'b0110;
    localparam logic [3:0] ALU_RSV7 = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLR  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_IN   = 4'b1100;
    localparam logic [3:0] ALU_OUT  = 4'b1101;
    localparam logic [3:0] ALU_RSVE = 4'b1110;
    localparam logic [3:0] ALU_RSVF = 4'b1111;

    // Shift kind is the low two bits of a shift opcode.
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SLR = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shift step: SLL, rotate-left, SRL or SRA by DIST bits (1 by default), plus the
// last bit shifted out. Rotate also reports a bit; the caller decides whether it becomes carry.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [1:0]       kind_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_o
);

    always_comb begin
        data_o = data_i;
        bit_o  = 1'b0;
        case (kind_i)
            SH_SLL: begin
                data_o = data_i << DIST;
                bit_o  = data_i[WIDTH-DIST];
            end
            SH_SLR: begin
                data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                bit_o  = data_i[WIDTH-DIST];
            end
            SH_SRL: begin
                data_o = data_i >> DIST;
                bit_o  = data_i[DIST-1];
            end
            SH_SRA: begin
                data_o = $unsigned($signed(data_i) >>> DIST);
                bit_o  = data_i[DIST-1];
            end
            default: begin
                data_o = data_i;
                bit_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic, iterative 1-bit-per-cycle shifts with start/busy/done.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_Cnt,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_s,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    alu_state_e state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   imm_res;
    logic               imm_c, imm_v, imm_keep;
    logic               accept, shift_issue, shift_last;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_S] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign shamt  = in_b[SHAMT_W-1:0];
    assign sum_w  = {1'b0, in_a} + {1'b0, in_b};
    assign diff_w = {1'b0, in_a} - {1'b0, in_b};
    // A new request is taken in IDLE and DONE alike, never while a shift is running.
    assign accept = start && (state_q != ST_SHIFT);

`ifdef ALU_BARREL_SHIFT_EN
    logic [SHAMT_W:0][WIDTH-1:0] bs_data;
    logic [SHAMT_W:0]            bs_bit;

    assign bs_data[0] = in_a;
    assign bs_bit[0]  = 1'b0;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_barrel
        logic [WIDTH-1:0] st_data;
        logic             st_bit;

        alu_shift_step #(.WIDTH(WIDTH), .DIST(1 << k)) u_step (
            .kind_i (ALU_Cnt[1:0]),
            .data_i (bs_data[k]),
            .data_o (st_data),
            .bit_o  (st_bit)
        );

        // The highest enabled stage shifts last, so its out-bit is the overall carry.
        assign bs_data[k+1] = shamt[k] ? st_data : bs_data[k];
        assign bs_bit[k+1]  = shamt[k] ? st_bit  : bs_bit[k];
    end

    assign shift_issue = 1'b0;
    assign shift_last  = 1'b0;
`else
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    alu_shift_step #(.WIDTH(WIDTH), .DIST(1)) u_step (
        .kind_i (op_q[1:0]),
        .data_i (work_q),
        .data_o (step_data),
        .bit_o  (step_bit)
    );

    assign shift_issue = accept && is_shift_op(ALU_Cnt) && (shamt != '0);
    assign shift_last  = (cnt_q == SHAMT_W'(1));

    always_comb begin
        op_d   = op_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        if (shift_issue) begin
            op_d   = ALU_Cnt;
            work_d = in_a;
            cnt_d  = shamt;
        end else if (state_q == ST_SHIFT) begin
            work_d = step_data;
            cnt_d  = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            op_q   <= op_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    always_comb begin
        imm_res  = '0;
        imm_c    = 1'b0;
        imm_v    = 1'b0;
        imm_keep = 1'b0;
        case (ALU_Cnt)
            ALU_ADD: begin
                imm_res = sum_w[WIDTH-1:0];
                imm_c   = sum_w[WIDTH];
                imm_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            ALU_SUB: begin
                imm_res = diff_w[WIDTH-1:0];
                imm_c   = diff_w[WIDTH];
                imm_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            ALU_AND: imm_res = in_a & in_b;
            ALU_OR:  imm_res = in_a | in_b;
            ALU_XOR: imm_res = in_a ^ in_b;
            ALU_MOV: imm_res = in_b;
            ALU_IN:  imm_res = in_b;
            ALU_OUT: imm_res = in_a;
            ALU_SLL, ALU_SLR, ALU_SRL, ALU_SRA: begin
`ifdef ALU_BARREL_SHIFT_EN
                imm_res = bs_data[SHAMT_W];
                imm_c   = bs_bit[SHAMT_W] && (ALU_Cnt != ALU_SLR);
`else
                // Only reached for a zero shift amount; nonzero amounts take the SHIFT path.
                imm_res = in_a;
`endif
            end
            default: imm_keep = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SHIFT: begin
                if (shift_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (accept) begin
                    state_d = shift_issue ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
`ifdef ALU_BARREL_SHIFT_EN
        busy = 1'b0;
`else
        busy = (state_q == ST_SHIFT);
`endif
        done = (state_q == ST_DONE);
    end

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (accept && !shift_issue) begin
            result_d = imm_res;
            if (!imm_keep) begin
                flags_d = mk_flags(imm_res, imm_c, imm_v);
            end
        end
`ifdef ALU_BARREL_SHIFT_EN
`else
        else if ((state_q == ST_SHIFT) && shift_last) begin
            result_d = step_data;
            flags_d  = mk_flags(step_data, step_bit && (op_q != ALU_SLR), 1'b0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flag_s = flags_q[FLAG_S];
    assign flag_z = flags_q[FLAG_Z];
    assign flag_c = flags_q[FLAG_C];
    assign flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: behavioural reference model with per-cycle comparison plus
// directed vectors carrying hand-computed results, flags and latencies.
`timescale 1ns/1ps
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        busy, done, flag_s, flag_z, flag_c, flag_v;
    logic [15:0] result;

    alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ALU_Cnt (op),
        .in_a    (a),
        .in_b    (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flag_s  (flag_s),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_v  (flag_v)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result, SZCV flags, whether flags are kept, and latency in cycles.
    function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic [3:0] f,
                                  output bit keep, output int lat);
        int n, sx, sy, s;
        logic c, v;
        n = int'(y[3:0]);
        sx = int'($signed(x));
        sy = int'($signed(y));
        c = 1'b0; v = 1'b0; keep = 1'b0; lat = 1; r = 16'h0;
        case (o)
            4'h0: begin r = x + y; c = (int'(x) + int'(y)) > 65535; s = sx + sy; v = (s > 32767) || (s < -32768); end
            4'h1: begin r = x - y; c = (x < y); s = sx - sy; v = (s > 32767) || (s < -32768); end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h6: r = y;
            4'h8: begin r = x << n; c = (n > 0) ? x[16-n] : 1'b0; lat = n + 1; end
            4'h9: begin r = (x << n) | (x >> (16 - n)); lat = n + 1; end
            4'hA: begin r = x >> n; c = (n > 0) ? x[n-1] : 1'b0; lat = n + 1; end
            4'hB: begin s = sx >>> n; r = 16'(s); c = (n > 0) ? x[n-1] : 1'b0; lat = n + 1; end
            4'hC: r = y;
            4'hD: r = x;
            default: begin keep = 1'b1; r = 16'h0; end
        endcase
        f = {r[15], (r == 16'h0), c, v};
    endfunction

    logic [15:0] m_res = 16'h0, p_res;
    logic [3:0]  m_f = 4'h0, p_f;
    bit          p_keep;
    int          busy_left = 0;
    bit          e_done = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        int lat;
        if (rst) begin
            busy_left = 0; m_res = 16'h0; m_f = 4'h0; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_res = p_res; if (!p_keep) m_f = p_f; e_done = 1'b1;
                end
            end else if (start) begin
                model(op, a, b, p_res, p_f, p_keep, lat);
                if (lat == 1) begin
                    m_res = p_res; if (!p_keep) m_f = p_f; e_done = 1'b1;
                end else begin
                    busy_left = lat - 1;
                end
            end
        end
        e_busy = (busy_left > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", busy, e_busy);
            chk("cyc_done", done, e_done);
            chk("cyc_result", result, m_res);
            chk("cyc_flags", {flag_s, flag_z, flag_c, flag_v}, m_f);
        end
    end

    task automatic start_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, input int exp_lat, input logic [15:0] er,
                             input logic [3:0] ef, input string name);
        int k;
        k = k0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            chk({name, "_done_timeout"}, done, 1);
        end else begin
            chk({name, "_latency"}, k, exp_lat);
            chk({name, "_result"}, result, er);
            chk({name, "_flags"}, {flag_s, flag_z, flag_c, flag_v}, ef);
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic [3:0] ef, input int lat, input string name);
        start_op(o, x, y);
        wait_done(1, lat, er, ef, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {flag_s, flag_z, flag_c, flag_v}, 0);

        //  op     a         b         result    SZCV     lat
        run(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, "add_ovf");
        run(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1, "sub_borrow");
        run(4'h1, 16'h1234, 16'h1234, 16'h0000, 4'b0100, 1, "sub_zero");
        run(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1, "sub_ovf");
        run(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1, "and");
        run(4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b1000, 1, "or");
        run(4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1, "xor");
        run(4'h6, 16'h1111, 16'h8000, 16'h8000, 4'b1000, 1, "mov");
        run(4'hC, 16'h0000, 16'h0042, 16'h0042, 4'b0000, 1, "in");
        run(4'hD, 16'h0000, 16'h5555, 16'h0000, 4'b0100, 1, "out");
        run(4'hB, 16'h8001, 16'h0003, 16'hF000, 4'b1000, 4, "sra3");
        run(4'h9, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 5, "slr4");
        run(4'hA, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 2, "srl1");
        run(4'h8, 16'hC000, 16'h0010, 16'hC000, 4'b1000, 1, "sll0");

        // Second start while busy must be ignored; operands change mid-shift.
        start_op(4'h8, 16'h0001, 16'h000F);
        start_op(4'h0, 16'h0002, 16'h0002);
        wait_done(2, 16, 16'h8000, 4'b1000, "sll15_ignore");

        // Reset in the middle of a long shift.
        start_op(4'h8, 16'h0001, 16'h000F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {flag_s, flag_z, flag_c, flag_v}, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        run(4'h0, 16'h0002, 16'h0002, 16'h0004, 4'b0000, 1, "add_after_rst");

        // Reserved code keeps previous flags but still clears result and pulses done once.
        run(4'h0, 16'h0001, 16'hFFFF, 16'h0000, 4'b0110, 1, "add_zero_carry");
        run(4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b0110, 1, "rsv_f");
        @(negedge clk);
        chk("rsv_single_pulse", done, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
